// File: rtl/shbus_pkg.sv
// Shared lane-control bus arbiter: FSM state encoding, default word width and grant decoding helper.
package shbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 3;
  localparam int unsigned MAX_REQ   = 8;

  // Index of the set bit of a one-hot grant vector (0 when empty).
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < int'(MAX_REQ); i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/shared_bus3_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request at or above ptr, wrapping past NREQ-1.
module rr_pick #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   idx
);

  logic [IW:0]   sum;
  logic [IW-1:0] pos;

  // Scan from farthest to nearest so the nearest hit to ptr wins.
  always_comb begin
    any = |req;
    idx = '0;
    sum = '0;
    pos = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      pos = IW'(sum);
      if (req[pos]) idx = pos;
    end
  end

endmodule

// File: rtl/shared_bus3_arbiter.sv
// Round-robin owner/turnaround sequencer for the shared lane-control bus.
// Optional tenure limit enabled by defining SHBUS_HOLD_LIMIT_EN.
module shared_bus3_arbiter
  import shbus_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ-1:0]       LAST,
  input  logic [NREQ*WIDTH-1:0] DATA_IN,
  output logic [NREQ-1:0]       GNT,
  output logic [WIDTH-1:0]      BUS_O,
  output logic                  BUS_VLD,
  output logic                  BUSY,
  output logic                  HOLD_EXP
);

  localparam int unsigned IW = $clog2(NREQ);

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   next_ptr;
  logic            pick_any;
  logic [IW-1:0]   pick_idx;
  logic            own_req;
  logic            own_last;
  logic            forced;
  logic            rel;
  logic [WIDTH-1:0] words [NREQ];

  for (genvar i = 0; i < int'(NREQ); i++) begin : g_words
    assign words[i] = DATA_IN[i*WIDTH +: WIDTH];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (REQ),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign owner    = IW'(onehot_to_idx(MAX_REQ'(GNT)));
  assign own_req  = REQ[owner];
  assign own_last = LAST[owner];
  assign next_ptr = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);

  // Data path follows the registered grant with no added latency.
  assign BUS_VLD = (state == OWN) && own_req;
  assign BUS_O   = BUS_VLD ? words[owner] : '0;
  assign BUSY    = (state != IDLE);

`ifdef SHBUS_HOLD_LIMIT_EN
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] cnt_inc;

  assign cnt_inc = hold_cnt + HW'(1);
  assign forced  = BUS_VLD && (cnt_inc == HW'(MAX_HOLD));
`else
  logic unused_max_hold;

  assign unused_max_hold = (MAX_HOLD == 0);
  assign forced          = 1'b0;
  assign HOLD_EXP        = 1'b0;
`endif

  assign rel = (state == OWN) && (!own_req || own_last || forced);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= IDLE;
      GNT    <= '0;
      rr_ptr <= '0;
`ifdef SHBUS_HOLD_LIMIT_EN
      hold_cnt <= '0;
      HOLD_EXP <= 1'b0;
`endif
    end else begin
`ifdef SHBUS_HOLD_LIMIT_EN
      HOLD_EXP <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_any) begin
            GNT   <= NREQ'(1) << pick_idx;
            state <= OWN;
          end
        end
        OWN: begin
`ifdef SHBUS_HOLD_LIMIT_EN
          if (BUS_VLD) hold_cnt <= cnt_inc;
`endif
          if (rel) begin
            GNT    <= '0;
            rr_ptr <= next_ptr;
            state  <= GAP;
`ifdef SHBUS_HOLD_LIMIT_EN
            hold_cnt <= '0;
            HOLD_EXP <= forced && !own_last;
`endif
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_bus3_arbiter.sv
// Scoreboard bench for shared_bus3_arbiter: directed scenarios then random traffic against a reference model.
module tb_shared_bus3_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 3;
  localparam int MAX_HOLD = 8;
  localparam int DW       = NREQ * WIDTH;
`ifdef SHBUS_HOLD_LIMIT_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [NREQ-1:0] REQ = '0;
  logic [NREQ-1:0] LAST = '0;
  logic [DW-1:0]   DATA_IN = '0;
  logic [NREQ-1:0] GNT;
  logic [WIDTH-1:0] BUS_O;
  logic            BUS_VLD;
  logic            BUSY;
  logic            HOLD_EXP;

  always #5 CLK = ~CLK;

  shared_bus3_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .REQ      (REQ),
    .LAST     (LAST),
    .DATA_IN  (DATA_IN),
    .GNT      (GNT),
    .BUS_O    (BUS_O),
    .BUS_VLD  (BUS_VLD),
    .BUSY     (BUSY),
    .HOLD_EXP (HOLD_EXP)
  );

  typedef struct { int cyc; int gnt; int busy; int vld; int data; int hx; } stat_t;
  typedef struct { int cyc; int gnt; int data; } beat_t;

  stat_t stat_q[$];
  beat_t beat_q[$];
  int    gnt_log[$];
  int    hx_pulses = 0;
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model: who owns the bus, whether we sit in the turnaround, priority start, beats so far.
  int m_state = 0;  // 0 idle, 1 owned, 2 turnaround
  int m_owner = 0;
  int m_ptr   = 0;
  int m_beats = 0;
  int m_hx    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return DW'($urandom);
  endfunction

  // Apply one cycle of inputs, predict this cycle's outputs, advance the model across the edge.
  task automatic drive_cycle(input logic rst_v, input logic [NREQ-1:0] req_v,
                             input logic [NREQ-1:0] last_v, input logic [DW-1:0] data_v);
    stat_t s;
    beat_t b;
    bit    forced;
    bit    found;
    int    j;
    RST_N   = rst_v;
    REQ     = req_v;
    LAST    = last_v;
    DATA_IN = data_v;
    s.cyc  = cyc;
    s.busy = (m_state != 0);
    s.gnt  = (m_state == 1) ? (1 << m_owner) : 0;
    s.vld  = (m_state == 1 && req_v[m_owner]) ? 1 : 0;
    s.data = s.vld ? int'(data_v[m_owner*WIDTH +: WIDTH]) : 0;
    s.hx   = (m_state == 2) ? m_hx : 0;
    stat_q.push_back(s);
    if (s.vld != 0) begin
      b.cyc = cyc; b.gnt = s.gnt; b.data = s.data;
      beat_q.push_back(b);
    end
    if (!rst_v) begin
      m_state = 0; m_owner = 0; m_ptr = 0; m_beats = 0; m_hx = 0;
    end else begin
      case (m_state)
        0: begin
          found = 0;
          for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (!found && req_v[j]) begin
              found = 1; m_owner = j; m_state = 1; m_beats = 0;
            end
          end
        end
        1: begin
          forced = 0;
          if (s.vld != 0) begin
            m_beats++;
            if (HOLD_ON && m_beats == MAX_HOLD) forced = 1;
          end
          if (!req_v[m_owner] || last_v[m_owner] || forced) begin
            m_hx    = (forced && !last_v[m_owner]) ? 1 : 0;
            m_ptr   = (m_owner + 1) % NREQ;
            m_state = 2;
            m_beats = 0;
          end
        end
        default: begin
          m_state = 0;
        end
      endcase
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Monitor: per-cycle status plus a beat pop whenever the DUT shows a valid beat.
  always @(negedge CLK) begin
    stat_t s;
    beat_t b;
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      chk("gnt", 32'(GNT), s.gnt);
      chk("busy", 32'(BUSY), s.busy);
      chk("bus_vld", 32'(BUS_VLD), s.vld);
      chk("bus_o", 32'(BUS_O), s.data);
      chk("hold_exp", 32'(HOLD_EXP), s.hx);
      if (HOLD_EXP === 1'b1) hx_pulses++;
    end
    if (BUS_VLD === 1'b1) begin
      gnt_log.push_back(int'(GNT));
      n_cmp++;
      if (beat_q.size() == 0) begin
        n_bad++;
        $display("FAIL beat_unexpected cycle %0d: got beat gnt %0h data %0h expected none", cyc, GNT, BUS_O);
      end else begin
        b = beat_q.pop_front();
        chk("beat_cycle", cyc, b.cyc);
        chk("beat_gnt", 32'(GNT), b.gnt);
        chk("beat_data", 32'(BUS_O), b.data);
      end
    end
  end

  logic [NREQ-1:0] req_r;
  logic [NREQ-1:0] rq;
  logic [NREQ-1:0] ls;
  logic [DW-1:0]   dv;
  logic            rs;
  bit              done;

  initial begin
    @(posedge CLK);
    #1;

    // Reset held with every lane requesting.
    repeat (4) drive_cycle(1'b0, 4'b1111, 4'b0000, rnd_data());

    // Single owner, LAST on its third beat.
    done = 0;
    for (int i = 0; i < 10; i++) begin
      rq = done ? 4'b0000 : 4'b0100;
      ls = (m_state == 1 && m_beats == 2) ? 4'b0100 : 4'b0000;
      dv = rnd_data();
      dv[2*WIDTH +: WIDTH] = 3'b101;
      drive_cycle(1'b1, rq, ls, dv);
      if (ls != 0) done = 1;
    end

    // Fairness: everyone requests, everyone ends on the first beat.
    repeat (2) drive_cycle(1'b0, 4'b0000, 4'b0000, rnd_data());
    gnt_log.delete();
    repeat (16) drive_cycle(1'b1, 4'b1111, 4'b1111, rnd_data());
    if (gnt_log.size() >= 5) begin
      chk("rr_order0", gnt_log[0], 1);
      chk("rr_order1", gnt_log[1], 2);
      chk("rr_order2", gnt_log[2], 4);
      chk("rr_order3", gnt_log[3], 8);
      chk("rr_order4", gnt_log[4], 1);
    end else begin
      chk("rr_order_len", gnt_log.size(), 5);
    end

    // Wrap: owner 2 moves the pointer to 3, owner 3 drops after two beats, lane 0 follows.
    drive_cycle(1'b0, 4'b0000, 4'b0000, rnd_data());
    gnt_log.delete();
    repeat (2) drive_cycle(1'b1, 4'b0100, 4'b0100, rnd_data());
    done = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_state == 1 && m_owner == 3 && m_beats == 2) done = 1;
      rq = done ? 4'b0001 : 4'b1001;
      drive_cycle(1'b1, rq, 4'b0000, rnd_data());
    end
    if (gnt_log.size() >= 4) begin
      chk("wrap_b1", gnt_log[1], 8);
      chk("wrap_b2", gnt_log[2], 8);
      chk("wrap_next", gnt_log[3], 1);
    end else begin
      chk("wrap_len", gnt_log.size(), 4);
    end

    // Long tenure on lane 1 with no LAST.
    drive_cycle(1'b0, 4'b0000, 4'b0000, rnd_data());
    gnt_log.delete();
    hx_pulses = 0;
    repeat (11) drive_cycle(1'b1, 4'b0010, 4'b0000, rnd_data());
    chk("hold_beats", gnt_log.size(), HOLD_ON ? 8 : 10);
    chk("hold_pulses", hx_pulses, HOLD_ON ? 1 : 0);

    // Reset on the second beat of a tenure, then a fresh request set.
    drive_cycle(1'b0, 4'b0000, 4'b0000, rnd_data());
    for (int i = 0; i < 5; i++) begin
      if (m_state == 1 && m_beats == 1) break;
      drive_cycle(1'b1, 4'b0100, 4'b0000, rnd_data());
    end
    drive_cycle(1'b0, 4'b0100, 4'b0000, rnd_data());
    gnt_log.delete();
    repeat (4) drive_cycle(1'b1, 4'b0110, 4'b0000, rnd_data());
    if (gnt_log.size() >= 1) chk("post_reset_owner", gnt_log[0], 2);
    else chk("post_reset_len", gnt_log.size(), 1);

    // Random traffic with occasional resets.
    drive_cycle(1'b0, 4'b0000, 4'b0000, rnd_data());
    req_r = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_r[i] && $urandom_range(3) == 0) req_r[i] = 1'b1;
      rq = req_r;
      ls = NREQ'($urandom);
      if (m_state == 1) begin
        ls[m_owner] = 1'b0;
        case ($urandom_range(9))
          0: begin rq[m_owner] = 1'b0; req_r[m_owner] = 1'b0; end
          1, 2: begin ls[m_owner] = 1'b1; req_r[m_owner] = 1'b0; end
          default: ;
        endcase
      end
      rs = ($urandom_range(299) != 0);
      drive_cycle(rs, rq, ls, rnd_data());
    end

    chk("beats_left", beat_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
